match_window_monitor: RTL

- Downstream consumer of the pipelined logic unit's per-cycle match pulse (its valid_out output).
- Splits the match stream into fixed windows of WINDOW_LEN sampled cycles. For each window it records the match count and the longest run of consecutive matches.
- Each completed window produces one report record. Records are buffered in a small FIFO and drained over a valid/ready handshake to a host/UART formatter.

---
 rtl/match_window_monitor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/match_window_monitor.sv
// Splits a per-cycle match stream into fixed windows and queues one
// {match count, longest run, window index} record per completed window.
module match_window_monitor #(
    parameter int WINDOW_LEN = 256,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clear,
    input  logic                          match_in,
    output logic                          rpt_valid,
    input  logic                          rpt_ready,
    output logic [CNT_W-1:0]              rpt_matches,
    output logic [CNT_W-1:0]              rpt_max_run,
    output logic [IDX_W-1:0]              rpt_win_idx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          active
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_WC  = CNT_W'(WINDOW_LEN - 1);
    localparam logic [PW:0]      FULL_LVL = (PW + 1)'(FIFO_DEPTH);

    generate
        if (WINDOW_LEN < 2 || WINDOW_LEN > (2 ** CNT_W) - 1 ||
            FIFO_DEPTH < 2 || (2 ** PW) != FIFO_DEPTH) begin : g_bad_param
            $error("match_window_monitor: illegal WINDOW_LEN/CNT_W/FIFO_DEPTH");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q;
    logic             active_q;
    logic [CNT_W-1:0] wc_q, mc_q, cr_q, mr_q;
    logic [CNT_W-1:0] wc_d, mc_d, cr_d, mr_d;
    logic [IDX_W-1:0] wi_q, wi_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    rd_q, wr_q;
    logic [PW:0]      cnt_q, cnt_d;

    logic [CNT_W-1:0] mem_mc [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_mr [FIFO_DEPTH];
    logic [IDX_W-1:0] mem_wi [FIFO_DEPTH];

    logic [CNT_W-1:0] mc_nx, cr_nx, mr_nx;
    logic             push, pop, full, wr_en, drop;

    // Next accumulator values include the current sample, so the window-end
    // record already counts the last cycle.
    assign mc_nx = mc_q + CNT_W'(match_in);
    assign cr_nx = match_in ? cr_q + CNT_W'(1) : '0;
    assign mr_nx = (cr_nx > mr_q) ? cr_nx : mr_q;

    assign push  = en && !clear && (wc_q == LAST_WC);
    assign pop   = rpt_valid && rpt_ready;
    assign full  = (cnt_q == FULL_LVL);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        wc_d  = wc_q;
        mc_d  = mc_q;
        cr_d  = cr_q;
        mr_d  = mr_q;
        wi_d  = wi_q;
        ovf_d = ovf_q;
        if (clear) begin
            wc_d  = '0;
            mc_d  = '0;
            cr_d  = '0;
            mr_d  = '0;
            wi_d  = '0;
            ovf_d = 1'b0;
        end else if (en) begin
            if (wc_q == LAST_WC) begin
                wc_d = '0;
                mc_d = '0;
                cr_d = '0;
                mr_d = '0;
                wi_d = wi_q + IDX_W'(1);
                if (drop) ovf_d = 1'b1;
            end else begin
                wc_d = wc_q + CNT_W'(1);
                mc_d = mc_nx;
                cr_d = cr_nx;
                mr_d = mr_nx;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q  <= '0;
            mc_q  <= '0;
            cr_q  <= '0;
            mr_q  <= '0;
            wi_q  <= '0;
            ovf_q <= 1'b0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wc_q  <= wc_d;
            mc_q  <= mc_d;
            cr_q  <= cr_d;
            mr_q  <= mr_d;
            wi_q  <= wi_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (wr_en) wr_q <= wr_q + PW'(1);
            if (pop)   rd_q <= rd_q + PW'(1);
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_mc[wr_q] <= mc_nx;
            mem_mr[wr_q] <= mr_nx;
            mem_wi[wr_q] <= wi_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (en) begin
                    state_q  <= RUN;
                    active_q <= 1'b1;
                end
                RUN: if (!en) begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign rpt_valid   = (cnt_q != '0);
    assign rpt_matches = rpt_valid ? mem_mc[rd_q] : '0;
    assign rpt_max_run = rpt_valid ? mem_mr[rd_q] : '0;
    assign rpt_win_idx = rpt_valid ? mem_wi[rd_q] : '0;
    assign fifo_level  = cnt_q;
    assign overflow    = ovf_q;
    assign active      = active_q;

endmodule
